// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared CSR addresses, mstatus bits, privilege levels and sequencer states
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;

  localparam int MS_SIE    = 1;
  localparam int MS_MIE    = 3;
  localparam int MS_SPIE   = 5;
  localparam int MS_MPIE   = 7;
  localparam int MS_SPP    = 8;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [1:0] PRIV_USER    = 2'd0;
  localparam logic [1:0] PRIV_SUPERV  = 2'd1;
  localparam logic [1:0] PRIV_MACHINE = 2'd3;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T_EPC,
    ST_T_CAUSE,
    ST_T_TVAL,
    ST_T_STATUS,
    ST_REDIR,
    ST_R_STATUS
  } state_e;

endpackage

// File: rtl/trap_status_next.sv
// rtl/trap_status_next.sv - next mstatus value for trap entry or xRET at M or S level
module trap_status_next
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [1:0]      mode,
  input  logic            is_trap,
  input  logic [1:0]      target_level,
  output logic [XLEN-1:0] mstatus_out
);

  // Stack or unstack the interrupt-enable and previous-privilege fields of the target level
  always_comb begin
    mstatus_out = mstatus_in;
    if (target_level == PRIV_MACHINE) begin
      if (is_trap) begin
        mstatus_out[MS_MPIE]             = mstatus_in[MS_MIE];
        mstatus_out[MS_MIE]              = 1'b0;
        mstatus_out[MS_MPP_HI:MS_MPP_LO] = mode;
      end else begin
        mstatus_out[MS_MIE]              = mstatus_in[MS_MPIE];
        mstatus_out[MS_MPIE]             = 1'b1;
        mstatus_out[MS_MPP_HI:MS_MPP_LO] = PRIV_USER;
      end
    end else begin
      if (is_trap) begin
        mstatus_out[MS_SPIE] = mstatus_in[MS_SIE];
        mstatus_out[MS_SIE]  = 1'b0;
        mstatus_out[MS_SPP]  = mode[0];
      end else begin
        mstatus_out[MS_SIE]  = mstatus_in[MS_SPIE];
        mstatus_out[MS_SPIE] = 1'b1;
        mstatus_out[MS_SPP]  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/xRET sequencer writing trap CSRs and redirecting the PC; TRAP_DELEG_EN enables S-mode delegation and sret
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int         XLEN       = 32,
  parameter logic [1:0] RESET_MODE = 2'd3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            excep_valid,
  input  logic [3:0]      excep_code,
  input  logic [XLEN-1:0] excep_pc,
  input  logic [XLEN-1:0] excep_tval,
  input  logic            ret_valid,
  input  logic [1:0]      ret_sel,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic [XLEN-1:0] stvec_in,
  input  logic [XLEN-1:0] sepc_in,
  input  logic [XLEN-1:0] medeleg_in,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [1:0]      mode,
  output logic            stall,
  output logic            flush,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [3:0]        code_q, code_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic              is_ret_q, is_ret_d;
  logic              to_s_q, to_s_d;
  logic [1:0]        mpp_q, mpp_d;
  logic [1:0]        mode_q, mode_d;

  logic [3:0]        eff_code;
  logic              deleg_hit;
  logic              sret_ok;
  logic [XLEN-1:0]   tvec_sel;
  logic [XLEN-1:0]   epc_sel;
  logic [XLEN-1:0]   target_base;
  logic [XLEN-1:0]   status_next;
  logic              unused_bits;

  // A converted uret/sret enters the trap path as an illegal instruction
  assign eff_code    = excep_valid ? excep_code : CAUSE_ILLEGAL;
  assign target_base = is_ret_q ? epc_sel : tvec_sel;

`ifdef TRAP_DELEG_EN
  assign deleg_hit   = medeleg_in[eff_code] && (mode_q <= PRIV_SUPERV);
  assign sret_ok     = 1'b1;
  assign tvec_sel    = to_s_q ? stvec_in : mtvec_in;
  assign epc_sel     = to_s_q ? sepc_in : mepc_in;
  assign unused_bits = ^target_base[1:0];
`else
  assign deleg_hit   = 1'b0;
  assign sret_ok     = 1'b0;
  assign tvec_sel    = mtvec_in;
  assign epc_sel     = mepc_in;
  assign unused_bits = ^{target_base[1:0], stvec_in, sepc_in, medeleg_in};
`endif

  trap_status_next #(.XLEN(XLEN)) u_status_next (
    .mstatus_in   (mstatus_in),
    .mode         (mode_q),
    .is_trap      (~is_ret_q),
    .target_level (to_s_q ? PRIV_SUPERV : PRIV_MACHINE),
    .mstatus_out  (status_next)
  );

  // Sequencer state, latched request fields and current privilege
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      code_q   <= '0;
      tval_q   <= '0;
      is_ret_q <= 1'b0;
      to_s_q   <= 1'b0;
      mpp_q    <= PRIV_USER;
      mode_q   <= RESET_MODE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      code_q   <= code_d;
      tval_q   <= tval_d;
      is_ret_q <= is_ret_d;
      to_s_q   <= to_s_d;
      mpp_q    <= mpp_d;
      mode_q   <= mode_d;
    end
  end

  // Next state and per-state CSR write, flush, stall and redirect outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    code_d      = code_q;
    tval_d      = tval_q;
    is_ret_d    = is_ret_q;
    to_s_d      = to_s_q;
    mpp_d       = mpp_q;
    mode_d      = mode_q;
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (excep_valid) begin
          state_d  = ST_T_EPC;
          pc_d     = excep_pc;
          code_d   = excep_code;
          tval_d   = excep_tval;
          is_ret_d = 1'b0;
          to_s_d   = deleg_hit;
        end else if (ret_valid) begin
          if (ret_sel == 2'd3 || (ret_sel == 2'd1 && sret_ok)) begin
            state_d  = ST_R_STATUS;
            is_ret_d = 1'b1;
            to_s_d   = (ret_sel == 2'd1);
          end else begin
            state_d  = ST_T_EPC;
            pc_d     = excep_pc;
            code_d   = CAUSE_ILLEGAL;
            tval_d   = '0;
            is_ret_d = 1'b0;
            to_s_d   = deleg_hit;
          end
        end
      end
      ST_T_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = to_s_q ? CSR_SEPC : CSR_MEPC;
        csr_wdata = pc_q;
        flush     = 1'b1;
        state_d   = ST_T_CAUSE;
      end
      ST_T_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = to_s_q ? CSR_SCAUSE : CSR_MCAUSE;
        csr_wdata = {{(XLEN-4){1'b0}}, code_q};
        state_d   = ST_T_TVAL;
      end
      ST_T_TVAL: begin
        csr_we    = 1'b1;
        csr_addr  = to_s_q ? CSR_STVAL : CSR_MTVAL;
        csr_wdata = tval_q;
        state_d   = ST_T_STATUS;
      end
      ST_T_STATUS: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = status_next;
        state_d   = ST_REDIR;
      end
      ST_R_STATUS: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = status_next;
        flush     = 1'b1;
        // Capture the return privilege now; mstatus_in shows the cleared field after this write
        mpp_d     = to_s_q ? {1'b0, mstatus_in[MS_SPP]} : mstatus_in[MS_MPP_HI:MS_MPP_LO];
        state_d   = ST_REDIR;
      end
      ST_REDIR: begin
        redirect    = 1'b1;
        redirect_pc = {target_base[XLEN-1:2], 2'b00};
        mode_d      = is_ret_q ? mpp_q : (to_s_q ? PRIV_SUPERV : PRIV_MACHINE);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mode = mode_q;

endmodule
